// File: rtl/snake_pkg.sv
// snake_pkg: shared UART FSM states, ASCII command codes and baud divisor helper
package snake_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} uartState_e;
  localparam logic [7:0] CMD_UP = 8'd65, CMD_DOWN = 8'd66, CMD_RIGHT = 8'd67, CMD_LEFT = 8'd68;
  function automatic int uart_div(input int clkFreq, input int baud);
    return (clkFreq + baud / 2) / baud;
  endfunction
endpackage

// File: rtl/uart_rx_cmd_if.sv
// uart_rx_cmd_if: serial line in, byte/strobe/frame-error out of the UART receiver
interface uart_rx_cmd_if;
  logic rx;
  logic [7:0] dataRX;
  logic WR_RX;
  logic frame_err;
  modport master(input rx, output dataRX, WR_RX, frame_err);
  modport slave(output rx, input dataRX, WR_RX, frame_err);
endinterface

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for asynchronous inputs with selectable reset value
module sync_2ff #(parameter logic RST_VAL = 1'b1) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;
  always_ff @(posedge clk)
    if (rst) {q, meta} <= {RST_VAL, RST_VAL};
    else {q, meta} <= {meta, d};
endmodule

// File: rtl/uart_rx_cmd.sv
// uart_rx_cmd: 8N1 UART receiver feeding bytes and a stretched strobe to the snake core
module uart_rx_cmd import snake_pkg::*; #(
  parameter int CLK_FREQ = 31_500_000,
  parameter int BAUD = 115200,
  parameter int WR_HOLD = 4
) (
  input logic px_clk,
  input logic rst,
  uart_rx_cmd_if.master bus
);
  localparam int DIV = uart_div(CLK_FREQ, BAUD);
  localparam int HALF = DIV / 2;
  localparam int CW = $clog2(DIV);
  localparam int HW = $clog2(WR_HOLD);
  uartState_e state, nState;
  logic [CW-1:0] cnt, nCnt;
  logic [2:0] idx, nIdx;
  logic [7:0] sh, nSh, dataReg, nData;
  logic [HW-1:0] hc;
  logic rxS, frameErr, nErr, load, wr;
  sync_2ff #(.RST_VAL(1'b1)) uSync (.clk(px_clk), .rst(rst), .d(bus.rx), .q(rxS));
  always_ff @(posedge px_clk)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      sh <= '0;
      dataReg <= '0;
      frameErr <= 1'b0;
    end else begin
      state <= nState;
      cnt <= nCnt;
      idx <= nIdx;
      sh <= nSh;
      dataReg <= nData;
      frameErr <= nErr;
    end
  always_comb begin
    nState = state;
    nCnt = cnt;
    nIdx = idx;
    nSh = sh;
    nData = dataReg;
    nErr = 1'b0;
    load = 1'b0;
    case (state)
      IDLE: if (!rxS) begin
        nState = START;
        nCnt = '0;
      end
      START: if (cnt == CW'(HALF - 1)) begin
        nCnt = '0;
        nIdx = '0;
        nState = rxS ? IDLE : DATA;
      end else nCnt = cnt + 1'b1;
      DATA: if (cnt == CW'(DIV - 1)) begin
        nCnt = '0;
        nSh = {rxS, sh[7:1]};
        nIdx = idx + 3'd1;
        nState = idx == 3'd7 ? STOP : DATA;
      end else nCnt = cnt + 1'b1;
      STOP: if (cnt == CW'(DIV - 1)) begin
        nCnt = '0;
        nData = rxS ? sh : dataReg;
        load = rxS;
        nErr = !rxS;
        nState = rxS ? IDLE : BREAK;
      end else nCnt = cnt + 1'b1;
      BREAK: nState = rxS ? IDLE : BREAK;
      default: nState = IDLE;
    endcase
  end
  // Strobe stretcher is free-running so a new start bit can be tracked while WR_RX is still high
  always_ff @(posedge px_clk)
    if (rst) begin
      wr <= 1'b0;
      hc <= '0;
    end else if (load) begin
      wr <= 1'b1;
      hc <= HW'(WR_HOLD - 1);
    end else if (hc != '0) hc <= hc - 1'b1;
    else wr <= 1'b0;
  assign bus.dataRX = dataReg;
  assign bus.WR_RX = wr;
  assign bus.frame_err = frameErr;
endmodule

// File: tb/tb_uart_rx_cmd.sv
// tb_uart_rx_cmd: directed checks of the UART receiver at DIV=10, WR_HOLD=4
module tb_uart_rx_cmd;
  import snake_pkg::*;
  logic px_clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0, fallCyc = 0, riseCyc = 0, curLen = 0, errCycles = 0;
  int compared = 0, mismatched = 0;
  logic prevWr = 1'b0;
  logic [7:0] got[$];
  int lens[$];
  int base;
  uart_rx_cmd_if bus();
  uart_rx_cmd #(.CLK_FREQ(1_000_000), .BAUD(100_000), .WR_HOLD(4)) dut (.px_clk(px_clk), .rst(rst), .bus(bus));
  always #5 px_clk = ~px_clk;
  always @(posedge px_clk) cyc <= cyc + 1;
  always @(negedge px_clk) begin
    prevWr <= bus.WR_RX;
    if (bus.frame_err) errCycles <= errCycles + 1;
    if (bus.WR_RX && !prevWr) begin
      got.push_back(bus.dataRX);
      riseCyc <= cyc;
      curLen <= 1;
    end else if (bus.WR_RX) curLen <= curLen + 1;
    if (!bus.WR_RX && prevWr) lens.push_back(curLen);
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // Caller sits on a posedge; a bit index equal to abortBit pulses rst mid-bit and abandons the frame
  task automatic sendByte(input logic [7:0] b, input logic stopBit, input int abortBit);
    #1 bus.rx = 1'b0;
    fallCyc = cyc;
    repeat (10) @(posedge px_clk);
    for (int i = 0; i < 8; i++) begin
      #1 bus.rx = b[i];
      if (i == abortBit) begin
        repeat (5) @(posedge px_clk);
        #1 rst = 1'b1;
        bus.rx = 1'b1;
        @(posedge px_clk);
        #1 check("rst_dataRX", 32'(bus.dataRX), 32'h0);
        check("rst_WR_RX", 32'(bus.WR_RX), 32'h0);
        check("rst_frame_err", 32'(bus.frame_err), 32'h0);
        rst = 1'b0;
        return;
      end
      repeat (10) @(posedge px_clk);
    end
    #1 bus.rx = stopBit;
    repeat (10) @(posedge px_clk);
  endtask
  initial begin
    bus.rx = 1'b1;
    repeat (3) @(posedge px_clk);
    #1 check("reset_dataRX", 32'(bus.dataRX), 32'h0);
    check("reset_WR_RX", 32'(bus.WR_RX), 32'h0);
    check("reset_frame_err", 32'(bus.frame_err), 32'h0);
    rst = 1'b0;
    repeat (5) @(posedge px_clk);
    sendByte(8'h41, 1'b1, -1);
    repeat (8) @(posedge px_clk);
    check("b41_pulses", 32'(got.size()), 32'd1);
    check("b41_data", 32'(got[$]), 32'h41);
    check("b41_len", 32'(lens[$]), 32'd4);
    check("b41_latency", 32'(riseCyc - fallCyc >= 97 && riseCyc - fallCyc <= 99), 32'd1);
    check("b41_ferr", 32'(errCycles), 32'd0);
    check("b41_dataRX", 32'(bus.dataRX), 32'h41);
    sendByte(8'h43, 1'b1, -1);
    sendByte(8'h44, 1'b1, -1);
    repeat (8) @(posedge px_clk);
    check("b2b_pulses", 32'(got.size()), 32'd3);
    check("b2b_first", 32'(got[$-1]), 32'h43);
    check("b2b_second", 32'(got[$]), 32'h44);
    check("b2b_len", 32'(lens[$]), 32'd4);
    #1 bus.rx = 1'b0;
    repeat (3) @(posedge px_clk);
    #1 bus.rx = 1'b1;
    repeat (20) @(posedge px_clk);
    check("glitch_pulses", 32'(got.size()), 32'd3);
    check("glitch_state", 32'(dut.state), 32'(IDLE));
    check("glitch_dataRX", 32'(bus.dataRX), 32'h44);
    sendByte(8'h55, 1'b0, -1);
    repeat (20) @(posedge px_clk);
    #1 bus.rx = 1'b1;
    repeat (20) @(posedge px_clk);
    check("ferr_cycles", 32'(errCycles), 32'd1);
    check("ferr_pulses", 32'(got.size()), 32'd3);
    check("ferr_dataRX", 32'(bus.dataRX), 32'h44);
    sendByte(8'h42, 1'b1, -1);
    repeat (8) @(posedge px_clk);
    check("after_ferr_pulses", 32'(got.size()), 32'd4);
    check("after_ferr_data", 32'(got[$]), 32'h42);
    check("after_ferr_once", 32'(errCycles), 32'd1);
    repeat (5) @(posedge px_clk);
    sendByte(8'h41, 1'b1, 4);
    repeat (30) @(posedge px_clk);
    check("abort_pulses", 32'(got.size()), 32'd4);
    sendByte(8'h44, 1'b1, -1);
    repeat (8) @(posedge px_clk);
    check("post_rst_pulses", 32'(got.size()), 32'd5);
    check("post_rst_data", 32'(got[$]), 32'h44);
    check("post_rst_dataRX", 32'(bus.dataRX), 32'h44);
    base = got.size();
    sendByte(8'h41, 1'b1, -1);
    sendByte(8'h41, 1'b1, -1);
    repeat (8) @(posedge px_clk);
    check("dup_pulses", 32'(got.size() - base), 32'd2);
    check("dup_first", 32'(got[$-1]), 32'h41);
    check("dup_second", 32'(got[$]), 32'h41);
    check("dup_len_first", 32'(lens[$-1]), 32'd4);
    check("dup_len_second", 32'(lens[$]), 32'd4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
